// File: rtl/mmac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mmac_operand_sequencer
// Purpose  : Upstream controller for matrix_mac_unit. Accepts a pair of packed
//            NxN matrices A and B and walks the MAC unit through every dot
//            product C[i][j] = sum_k A[i][k]*B[k][j]. Each finished element is
//            captured from the MAC result and streamed out row-major.
// Ports    : clock, reset      - clock / synchronous active-low reset
//            in_valid/in_ready - A/B pair handshake; in_a/in_b packed with
//                                element [i][j] at bits (i*N+j)*DW +: DW
//            mac_a/mac_b       - operands to the MAC unit (0 outside MAC)
//            mac_enable/clear  - accumulate / clear controls to the MAC unit
//            mac_result        - combinational accumulator value from the MAC
//            out_valid/ready   - result element handshake
//            out_data/row/col  - C[i][j] (mod 2^DW) and its coordinates
//            out_last          - marks element (N-1,N-1)
//            busy              - high whenever the sequencer is not idle
// Revision : 1.0 - initial release
// ============================================================================
module mmac_operand_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N*N*DATA_WIDTH-1:0]      in_a,
   input  logic [N*N*DATA_WIDTH-1:0]      in_b,
   output logic [DATA_WIDTH-1:0]          mac_a,
   output logic [DATA_WIDTH-1:0]          mac_b,
   output logic                           mac_enable,
   output logic                           mac_clear,
   input  logic [DATA_WIDTH-1:0]          mac_result,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic [$clog2(N)-1:0]           out_row,
   output logic [$clog2(N)-1:0]           out_col,
   output logic                           out_last,
   output logic                           busy
);

   localparam int                  IDX_W    = $clog2(N);
   localparam int                  MAT_W    = N*N*DATA_WIDTH;
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N-1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_MAC  = 2'd2,
      ST_CAP  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        i_q, i_d;
   logic [IDX_W-1:0]        j_q, j_d;
   logic [IDX_W-1:0]        k_q, k_d;
   logic [MAT_W-1:0]        a_q, a_d;
   logic [MAT_W-1:0]        b_q, b_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic [IDX_W-1:0]        out_row_q, out_row_d;
   logic [IDX_W-1:0]        out_col_q, out_col_d;
   logic                    out_last_q, out_last_d;

   int unsigned             a_sel;
   int unsigned             b_sel;
   logic                    cap_load;
   logic                    cap_is_last;

   always_comb begin
      // Flat element indices of A[i][k] and B[k][j] in the packed matrices.
      a_sel       = 32'(i_q) * N + 32'(k_q);
      b_sel       = 32'(k_q) * N + 32'(j_q);
      // Output register can take a new element if empty or draining now.
      cap_load    = !out_valid_q || out_ready;
      cap_is_last = (i_q == LAST_IDX) && (j_q == LAST_IDX);

      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      k_d         = k_q;
      a_d         = a_q;
      b_d         = b_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      out_last_d  = out_last_q;
      in_ready    = 1'b0;
      mac_enable  = 1'b0;
      mac_clear   = 1'b0;
      mac_a       = '0;
      mac_b       = '0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = ST_CLR;
            end
         end

         ST_CLR: begin
            mac_clear = 1'b1;
            state_d   = ST_MAC;
         end

         ST_MAC: begin
            mac_enable = 1'b1;
            mac_a      = a_q[a_sel*DATA_WIDTH +: DATA_WIDTH];
            mac_b      = b_q[b_sel*DATA_WIDTH +: DATA_WIDTH];
            if (k_q == LAST_IDX) begin
               k_d     = '0;
               state_d = ST_CAP;
            end else begin
               k_d     = k_q + 1'b1;
            end
         end

         ST_CAP: begin
            // With enable low the MAC result is the settled dot product.
            // If the output register is full and not draining, hold here with
            // enable and clear low so the accumulator keeps its value.
            if (cap_load) begin
               out_valid_d = 1'b1;
               out_data_d  = mac_result;
               out_row_d   = i_q;
               out_col_d   = j_q;
               out_last_d  = cap_is_last;
               mac_clear   = 1'b1;
               k_d         = '0;
               if (cap_is_last) begin
                  i_d     = '0;
                  j_d     = '0;
                  state_d = ST_IDLE;
               end else begin
                  if (j_q == LAST_IDX) begin
                     j_d = '0;
                     i_d = i_q + 1'b1;
                  end else begin
                     j_d = j_q + 1'b1;
                  end
                  state_d = ST_MAC;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         k_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         k_q         <= k_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mmac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmac_operand_sequencer
// Purpose  : Directed self-checking bench for mmac_operand_sequencer with a
//            behavioural MAC accumulator attached (N=4, DATA_WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmac_operand_sequencer;

   localparam int DW    = 8;
   localparam int N     = 4;
   localparam int MAT_W = N*N*DW;

   logic              clock;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [MAT_W-1:0]  in_a;
   logic [MAT_W-1:0]  in_b;
   logic [DW-1:0]     mac_a;
   logic [DW-1:0]     mac_b;
   logic              mac_enable;
   logic              mac_clear;
   logic [DW-1:0]     mac_result;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_row;
   logic [1:0]        out_col;
   logic              out_last;
   logic              busy;

   int checks   = 0;
   int failures = 0;

   mmac_operand_sequencer #(
      .DATA_WIDTH (DW),
      .N          (N)
   ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mac_a      (mac_a),
      .mac_b      (mac_b),
      .mac_enable (mac_enable),
      .mac_clear  (mac_clear),
      .mac_result (mac_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_last   (out_last),
      .busy       (busy)
   );

   // Behavioural MAC: accumulates at DW bits, result is the accumulator.
   logic [DW-1:0] acc_q;
   always_ff @(posedge clock) begin
      if (!reset || mac_clear) acc_q <= '0;
      else if (mac_enable)     acc_q <= acc_q + mac_a * mac_b;
   end
   assign mac_result = acc_q;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [MAT_W-1:0] mk_pat(input int mul, input int add);
      logic [MAT_W-1:0] m;
      m = '0;
      for (int e = 0; e < N*N; e++) m[e*DW +: DW] = 8'((e*mul + add) & 255);
      return m;
   endfunction

   function automatic logic [MAT_W-1:0] mk_ident();
      logic [MAT_W-1:0] m;
      m = '0;
      for (int d = 0; d < N; d++) m[(d*N+d)*DW +: DW] = 8'd1;
      return m;
   endfunction

   function automatic logic [MAT_W-1:0] ref_mul(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
      logic [MAT_W-1:0] c;
      logic [DW-1:0]    s;
      c = '0;
      for (int r = 0; r < N; r++) begin
         for (int q = 0; q < N; q++) begin
            s = '0;
            for (int t = 0; t < N; t++) s = s + a[(r*N+t)*DW +: DW] * b[(t*N+q)*DW +: DW];
            c[(r*N+q)*DW +: DW] = s;
         end
      end
      return c;
   endfunction

   task automatic start(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
      int g;
      g = 0;
      while (!in_ready && g < 200) begin
         tick();
         g++;
      end
      check_eq("start_in_ready", 32'(in_ready), 32'd1);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Receives the 16 elements following an accept edge. Optional stall,
   // busy-input pulse and mid-run reset are selected by element index.
   task automatic collect(input logic [MAT_W-1:0] exp_c, input int stall_idx,
                          input int pulse_idx, input int abort_idx, input bit chk_timing);
      int idx, cyc, prev, guard, bad_stable, bad_mac;
      bit pulse_on;
      idx = 0; cyc = 1; prev = 0; guard = 0; pulse_on = 1'b0;
      while (idx < N*N && guard < 1000) begin
         if (out_valid) begin
            if (idx == abort_idx) begin
               reset = 1'b0;
               tick();
               check_eq("rst_out_valid", 32'(out_valid), 32'd0);
               check_eq("rst_mac_en",    32'(mac_enable), 32'd0);
               check_eq("rst_mac_clr",   32'(mac_clear), 32'd0);
               check_eq("rst_mac_a",     32'(mac_a), 32'd0);
               check_eq("rst_mac_b",     32'(mac_b), 32'd0);
               check_eq("rst_in_ready",  32'(in_ready), 32'd1);
               check_eq("rst_busy",      32'(busy), 32'd0);
               reset = 1'b1;
               tick();
               return;
            end
            if (chk_timing) begin
               if (idx == 0) check_eq("first_latency", 32'(cyc), 32'd7);
               else          check_eq($sformatf("spacing[%0d]", idx), 32'(cyc - prev), 32'd5);
               if (idx == N*N-1) check_eq("ready_after_last", 32'(in_ready), 32'd1);
               prev = cyc;
            end
            if (idx == stall_idx) begin
               out_ready  = 1'b0;
               bad_stable = 0;
               bad_mac    = 0;
               for (int s = 0; s < 10; s++) begin
                  if (out_valid !== 1'b1 || out_data !== exp_c[idx*DW +: DW] ||
                      32'(out_row) != idx / N || 32'(out_col) != idx % N) bad_stable++;
                  if (s >= 5 && (mac_enable || mac_clear)) bad_mac++;
                  tick();
               end
               out_ready = 1'b1;
               check_eq("stall_stable",   32'(bad_stable), 32'd0);
               check_eq("stall_mac_idle", 32'(bad_mac), 32'd0);
            end
            if (idx == pulse_idx) begin
               in_a     = mk_pat(0, 255);
               in_b     = mk_pat(0, 255);
               in_valid = 1'b1;
               pulse_on = 1'b1;
               check_eq("busy_in_ready", 32'(in_ready), 32'd0);
               check_eq("busy_flag",     32'(busy), 32'd1);
            end
            check_eq($sformatf("data[%0d]", idx), 32'(out_data), 32'(exp_c[idx*DW +: DW]));
            check_eq($sformatf("row[%0d]", idx),  32'(out_row), 32'(idx / N));
            check_eq($sformatf("col[%0d]", idx),  32'(out_col), 32'(idx % N));
            check_eq($sformatf("last[%0d]", idx), 32'(out_last), 32'(idx == N*N-1));
            idx++;
         end
         tick();
         if (pulse_on) begin
            in_valid = 1'b0;
            pulse_on = 1'b0;
         end
         cyc++;
         guard++;
      end
      check_eq("elements_seen", 32'(idx), (abort_idx >= 0) ? 32'(abort_idx) : 32'(N*N));
   endtask

   logic [MAT_W-1:0] ma, mb;

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      tick(); tick(); tick();
      check_eq("reset_out_valid", 32'(out_valid), 32'd0);
      check_eq("reset_busy",      32'(busy), 32'd0);
      check_eq("reset_in_ready",  32'(in_ready), 32'd1);
      check_eq("reset_mac_en",    32'(mac_enable), 32'd0);
      check_eq("reset_mac_clr",   32'(mac_clear), 32'd0);
      check_eq("reset_out_data",  32'(out_data), 32'd0);
      check_eq("reset_out_last",  32'(out_last), 32'd0);
      reset = 1'b1;
      tick();

      // Identity times 0x01..0x10 returns B, with latency and spacing checks.
      mb = mk_pat(1, 1);
      start(mk_ident(), mb);
      collect(mb, -1, -1, -1, 1'b1);

      // All ones: every element is 4.
      start(mk_pat(0, 1), mk_pat(0, 1));
      collect({16{8'h04}}, -1, -1, -1, 1'b0);

      // All 0xFF: 4 * 0xFE01 = 0x3F804, low byte 0x04.
      start(mk_pat(0, 255), mk_pat(0, 255));
      collect({16{8'h04}}, -1, -1, -1, 1'b0);

      // Backpressure while element (0,2) is presented.
      ma = mk_pat(1, 1);
      mb = mk_pat(2, 3);
      start(ma, mb);
      collect(ref_mul(ma, mb), 2, -1, -1, 1'b0);

      // Pair offered while busy must be ignored.
      ma = mk_pat(5, 7);
      mb = mk_pat(3, 90);
      start(ma, mb);
      collect(ref_mul(ma, mb), -1, 5, -1, 1'b0);

      // Reset while element (1,1) is being accumulated, then a fresh run.
      start(mk_pat(7, 2), mk_pat(11, 5));
      collect(ref_mul(mk_pat(7, 2), mk_pat(11, 5)), -1, -1, 4, 1'b0);
      ma = mk_pat(9, 4);
      mb = mk_pat(13, 1);
      start(ma, mb);
      collect(ref_mul(ma, mb), -1, -1, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
